// File: rtl/mdu_ctrl.sv
// Multiply/divide scheduler: sequences a fixed-latency MDU busy window, owns HI/LO,
// and requests a decode-stage stall while a HI/LO user waits behind a busy MDU.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    md_op_e           op;
    logic             is_mul;
    logic             is_div;
    logic             start;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;

    assign op     = md_op_e'(E_md_op);
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign start  = (is_mul || is_div) && !busy;

    assign md_stall = D_md_use && (start || busy);

    // Both products are formed at 64 bits from extended operands; the low 64 bits
    // of the wide product are exact for either signedness.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    assign prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    assign prod_u = {32'b0, E_A} * {32'b0, E_B};

    // One unsigned divider serves div and divu. Signed division works on magnitudes so
    // 0x80000000 / -1 needs no special case.
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_safe;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign neg_a    = (op == OP_DIV) && E_A[31];
    assign neg_b    = (op == OP_DIV) && E_B[31];
    assign mag_a    = neg_a ? -E_A : E_A;
    assign mag_b    = neg_b ? -E_B : E_B;
    assign div_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign quo_mag  = mag_a / div_safe;
    assign rem_mag  = mag_a % div_safe;
    assign quo      = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
    assign rem      = neg_a ? -rem_mag : rem_mag;

    logic [31:0] nxt_hi;
    logic [31:0] nxt_lo;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        nxt_hi = HI;
        nxt_lo = LO;
        case (op)
            OP_MULT:  {nxt_hi, nxt_lo} = prod_s;
            OP_MULTU: {nxt_hi, nxt_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (E_B != 32'd0) begin
                    nxt_hi = rem;
                    nxt_lo = quo;
                end
            end
            default: ;
        endcase
    end

    // Ops arriving while busy are dropped; the stall keeps legal flow from issuing them.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                HI   <= pend_hi;
                LO   <= pend_lo;
                busy <= 1'b0;
            end
        end else if (start) begin
            pend_hi <= nxt_hi;
            pend_lo <= nxt_lo;
            cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            busy    <= 1'b1;
        end else if (op == OP_MTHI) begin
            HI <= E_A;
        end else if (op == OP_MTLO) begin
            LO <= E_A;
        end
    end

endmodule
